mux_rr_arbiter: RTL and testbench

- Shares one WIDTH-bit output channel between two requesters, each with its own data input.
- Picks a requester using a 2-way round-robin and drives the select of a mux2x1 instance.
- Registers the selected word and presents it downstream with a Valid/Ready handshake.
- Sits in front of the adder datapath so two operand sources can feed one adder input.

---
 rtl/mux_rr_arbiter_pkg.sv | 13 +
 rtl/mux_rr_arbiter_mux2x1.sv | 13 +
 rtl/mux_rr_arbiter.sv | 87 ++++++++
 tb/tb_mux_rr_arbiter.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/mux_rr_arbiter_pkg.sv
// Shared definitions for mux_rr_arbiter: 1-bit FSM state encodings and the
// reset value of the round-robin "last granted" pointer.
package mux_rr_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } arb_state_t;

  // Last=1 at reset so requester 0 wins the first tie.
  localparam logic LAST_RESET = 1'b1;

endpackage

// File: rtl/mux_rr_arbiter_mux2x1.sv
// Plain 2:1 word selector used as the arbiter's data path (S=0 -> A, S=1 -> B).
module mux2x1 #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             S,
  output logic [WIDTH-1:0] Y
);

  assign Y = S ? B : A;

endmodule

// File: rtl/mux_rr_arbiter.sv
// Two-requester round-robin arbiter feeding a registered Valid/Ready output word.
// Optional per-requester saturating grant counters when GRANT_CNT_EN is defined.
module mux_rr_arbiter
  import mux_rr_arbiter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Req0,
  input  logic             Req1,
  input  logic [WIDTH-1:0] In0,
  input  logic [WIDTH-1:0] In1,
  output logic             Gnt0,
  output logic             Gnt1,
  output logic [WIDTH-1:0] Y,
  output logic             Valid,
  input  logic             Ready,
`ifdef GRANT_CNT_EN
  output logic [CNT_W-1:0] Cnt0,
  output logic [CNT_W-1:0] Cnt1,
`endif
  output logic             Sel
);

  arb_state_t       state_reg;
  logic [WIDTH-1:0] y_reg;
  logic             sel_reg;
  logic             last_reg;
  logic [WIDTH-1:0] mux_y;
  logic             choice;
  logic             load;

  // A tie goes to whoever was not served last; a lone request always wins.
  assign choice = (Req0 && Req1) ? ~last_reg : Req1;
  assign load   = !rst && (Req0 || Req1) &&
                  ((state_reg == IDLE) || ((state_reg == FULL) && Ready));

  assign Gnt0  = load && !choice;
  assign Gnt1  = load && choice;
  assign Y     = y_reg;
  assign Sel   = sel_reg;
  assign Valid = (state_reg == FULL);

  mux2x1 #(.WIDTH(WIDTH)) u_mux (
    .A (In0),
    .B (In1),
    .S (choice),
    .Y (mux_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      y_reg     <= '0;
      sel_reg   <= 1'b0;
      last_reg  <= LAST_RESET;
    end else if (load) begin
      state_reg <= FULL;
      y_reg     <= mux_y;
      sel_reg   <= choice;
      last_reg  <= choice;
    end else if ((state_reg == FULL) && Ready) begin
      state_reg <= IDLE;
    end
  end

`ifdef GRANT_CNT_EN
  logic [CNT_W-1:0] cnt0_reg;
  logic [CNT_W-1:0] cnt1_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_reg <= '0;
      cnt1_reg <= '0;
    end else begin
      if (Gnt0 && !(&cnt0_reg)) cnt0_reg <= cnt0_reg + 1'b1;
      if (Gnt1 && !(&cnt1_reg)) cnt1_reg <= cnt1_reg + 1'b1;
    end
  end

  assign Cnt0 = cnt0_reg;
  assign Cnt1 = cnt1_reg;
`endif

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed self-checking bench for mux_rr_arbiter (counter scenario only when GRANT_CNT_EN).
module tb_mux_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       Req0, Req1, Ready;
  logic [7:0] In0, In1;
  logic       Gnt0, Gnt1, Valid, Sel;
  logic [7:0] Y;
`ifdef GRANT_CNT_EN
  logic [1:0] Cnt0, Cnt1;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mux_rr_arbiter #(.WIDTH(8), .CNT_W(2)) dut (
    .clk   (clk),
    .rst   (rst),
    .Req0  (Req0),
    .Req1  (Req1),
    .In0   (In0),
    .In1   (In1),
    .Gnt0  (Gnt0),
    .Gnt1  (Gnt1),
    .Y     (Y),
    .Valid (Valid),
    .Ready (Ready),
`ifdef GRANT_CNT_EN
    .Cnt0  (Cnt0),
    .Cnt1  (Cnt1),
`endif
    .Sel   (Sel)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; Req0 = 1'b0; Req1 = 1'b0; In0 = 8'h00; In1 = 8'h00; Ready = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (Valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", Valid); end
    n_checks++; if (Y !== 8'h00) begin n_fail++; $display("FAIL reset_y got %h exp 00", Y); end
    n_checks++; if (Sel !== 1'b0) begin n_fail++; $display("FAIL reset_sel got %b exp 0", Sel); end
    $display("reset: Valid=%b Y=%h Sel=%b", Valid, Y, Sel);
  endtask

  task automatic test_single();
    do_reset();
    Req0 = 1'b1; In0 = 8'h3C; Ready = 1'b1;
    #1;
    n_checks++; if (Gnt0 !== 1'b1) begin n_fail++; $display("FAIL single_gnt0 got %b exp 1", Gnt0); end
    n_checks++; if (Gnt1 !== 1'b0) begin n_fail++; $display("FAIL single_gnt1 got %b exp 0", Gnt1); end
    tick();
    Req0 = 1'b0;
    n_checks++; if (Y !== 8'h3C) begin n_fail++; $display("FAIL single_y got %h exp 3c", Y); end
    n_checks++; if (Valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b exp 1", Valid); end
    n_checks++; if (Sel !== 1'b0) begin n_fail++; $display("FAIL single_sel got %b exp 0", Sel); end
    $display("single: Y=%h Valid=%b Sel=%b", Y, Valid, Sel);
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_y [4];
    logic       exp_g [4];
    exp_y[0] = 8'hA0; exp_y[1] = 8'h05; exp_y[2] = 8'hA0; exp_y[3] = 8'h05;
    exp_g[0] = 1'b0;  exp_g[1] = 1'b1;  exp_g[2] = 1'b0;  exp_g[3] = 1'b1;
    do_reset();
    Req0 = 1'b1; Req1 = 1'b1; In0 = 8'hA0; In1 = 8'h05; Ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if (Gnt1 !== exp_g[i] || Gnt0 !== !exp_g[i]) begin
        n_fail++; $display("FAIL b2b_gnt[%0d] got Gnt0=%b Gnt1=%b exp Gnt1=%b", i, Gnt0, Gnt1, exp_g[i]);
      end
      tick();
      n_checks++;
      if (Y !== exp_y[i] || Sel !== exp_g[i] || Valid !== 1'b1) begin
        n_fail++; $display("FAIL b2b_y[%0d] got Y=%h Sel=%b Valid=%b exp Y=%h Sel=%b", i, Y, Sel, Valid, exp_y[i], exp_g[i]);
      end
      $display("b2b[%0d]: Y=%h Sel=%b", i, Y, Sel);
    end
    Req0 = 1'b0; Req1 = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    Req0 = 1'b1; In0 = 8'h11; Ready = 1'b1;
    tick();
    Req0 = 1'b0; Req1 = 1'b1; In1 = 8'h22; Ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (Gnt1 !== 1'b0) begin n_fail++; $display("FAIL bp_gnt1[%0d] got %b exp 0", i, Gnt1); end
      tick();
      n_checks++;
      if (Y !== 8'h11 || Valid !== 1'b1 || Sel !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold[%0d] got Y=%h Valid=%b Sel=%b exp Y=11 Valid=1 Sel=0", i, Y, Valid, Sel);
      end
      $display("stall[%0d]: Y=%h Valid=%b", i, Y, Valid);
    end
    Ready = 1'b1;
    #1;
    n_checks++; if (Gnt1 !== 1'b1) begin n_fail++; $display("FAIL bp_release_gnt1 got %b exp 1", Gnt1); end
    tick();
    Req1 = 1'b0;
    n_checks++;
    if (Y !== 8'h22 || Sel !== 1'b1 || Valid !== 1'b1) begin
      n_fail++; $display("FAIL bp_release_y got Y=%h Sel=%b Valid=%b exp Y=22 Sel=1 Valid=1", Y, Sel, Valid);
    end
    tick();
    n_checks++; if (Valid !== 1'b0) begin n_fail++; $display("FAIL drain_valid got %b exp 0", Valid); end
    $display("release: drained Valid=%b", Valid);
  endtask

  task automatic test_mid_reset();
    do_reset();
    Req0 = 1'b1; In0 = 8'hFF; Ready = 1'b0;
    tick();
    rst = 1'b1; Req1 = 1'b1; In1 = 8'h77; In0 = 8'h99;
    #1;
    n_checks++;
    if (Gnt0 !== 1'b0 || Gnt1 !== 1'b0) begin
      n_fail++; $display("FAIL rst_gnt got Gnt0=%b Gnt1=%b exp 0 0", Gnt0, Gnt1);
    end
    tick();
    n_checks++;
    if (Valid !== 1'b0 || Y !== 8'h00 || Sel !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid got Valid=%b Y=%h Sel=%b exp 0 00 0", Valid, Y, Sel);
    end
    rst = 1'b0; Ready = 1'b1;
    #1;
    n_checks++; if (Gnt0 !== 1'b1 || Gnt1 !== 1'b0) begin n_fail++; $display("FAIL rst_first_gnt got Gnt0=%b Gnt1=%b exp 1 0", Gnt0, Gnt1); end
    tick();
    n_checks++; if (Y !== 8'h99 || Sel !== 1'b0) begin n_fail++; $display("FAIL rst_first_y got Y=%h Sel=%b exp 99 0", Y, Sel); end
    Req0 = 1'b0; Req1 = 1'b0;
    $display("mid_reset: Y=%h Sel=%b", Y, Sel);
  endtask

`ifdef GRANT_CNT_EN
  task automatic test_grant_cnt();
    logic [1:0] exp_c [5];
    exp_c[0] = 2'd1; exp_c[1] = 2'd2; exp_c[2] = 2'd3; exp_c[3] = 2'd3; exp_c[4] = 2'd3;
    do_reset();
    n_checks++; if (Cnt0 !== 2'd0) begin n_fail++; $display("FAIL cnt_reset got %0d exp 0", Cnt0); end
    Req0 = 1'b1; In0 = 8'h42; Ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (Cnt0 !== exp_c[i] || Cnt1 !== 2'd0) begin
        n_fail++; $display("FAIL cnt[%0d] got Cnt0=%0d Cnt1=%0d exp %0d 0", i, Cnt0, Cnt1, exp_c[i]);
      end
      $display("cnt[%0d]: Cnt0=%0d Cnt1=%0d", i, Cnt0, Cnt1);
    end
    Req0 = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1; Req0 = 1'b0; Req1 = 1'b0; In0 = 8'h00; In1 = 8'h00; Ready = 1'b0;
    #2;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_mid_reset();
`ifdef GRANT_CNT_EN
    test_grant_cnt();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
